// File: rtl/my_lsu.sv
// Load/store unit between execute and my_dmem: byte/half/word accesses,
// word-crossing accesses split into two aligned dmem cycles, load extension.
module my_lsu #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        dmem_we_o,
   output logic [3:0]  dmem_wmask_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_we, r_uns, r_err, r_split;
   logic [1:0]  r_size, r_off;
   logic [3:0]  r_bm_hi;
   logic [31:0] r_wdata, r_buf;

   logic        w_accept, w_split, w_err;
   logic [1:0]  w_off;
   logic [2:0]  w_n;
   logic [7:0]  w_bm_base, w_bm;
   logic [5:0]  w_sh_hi;
   logic [31:0] w_ext;
   logic        w_we_nxt;
   logic [3:0]  w_mask_nxt;
   logic [31:0] w_addr_nxt, w_wdata_nxt;

   assign req_ready_o = (r_state == S_IDLE);
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_off       = req_addr_i[1:0];

   always_comb begin
      w_n       = 3'd4;
      w_bm_base = 8'h0F;
      case (req_size_i)
         2'b00:   begin w_n = 3'd1; w_bm_base = 8'h01; end
         2'b01:   begin w_n = 3'd2; w_bm_base = 8'h03; end
         default: ;
      endcase
   end

   assign w_bm    = w_bm_base << w_off;
   assign w_split = (({1'b0, w_off} + w_n) > 3'd4);
   assign w_err   = (req_size_i == 2'b11) || (w_split && !ALLOW_MISALIGNED);
   // Shift that brings the upper bytes of a split access into / out of lane 0
   assign w_sh_hi = {3'd4 - {1'b0, r_off}, 3'b000};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_we_nxt    = 1'b0;
      w_mask_nxt  = 4'b0;
      w_addr_nxt  = 32'b0;
      w_wdata_nxt = 32'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_err) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_FIRST;
                  w_we_nxt    = req_we_i;
                  w_mask_nxt  = w_bm[3:0];
                  w_addr_nxt  = {req_addr_i[31:2], 2'b00};
                  w_wdata_nxt = req_wdata_i << {w_off, 3'b000};
               end
            end
         end
         S_FIRST: begin
            if (r_split) begin
               w_state_nxt = S_SECOND;
               w_we_nxt    = r_we;
               w_mask_nxt  = r_bm_hi;
               w_addr_nxt  = {dmem_addr_o[31:2] + 30'd1, 2'b00};
               w_wdata_nxt = r_wdata >> w_sh_hi;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_SECOND: w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_we_o    <= 1'b0;
         dmem_wmask_o <= 4'b0;
         dmem_addr_o  <= 32'b0;
         dmem_wdata_o <= 32'b0;
         r_we         <= 1'b0;
         r_uns        <= 1'b0;
         r_err        <= 1'b0;
         r_split      <= 1'b0;
         r_size       <= 2'b0;
         r_off        <= 2'b0;
         r_bm_hi      <= 4'b0;
         r_wdata      <= 32'b0;
         r_buf        <= 32'b0;
      end else begin
         dmem_we_o    <= w_we_nxt;
         dmem_wmask_o <= w_mask_nxt;
         dmem_addr_o  <= w_addr_nxt;
         dmem_wdata_o <= w_wdata_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we    <= req_we_i;
                  r_uns   <= req_unsigned_i;
                  r_err   <= w_err;
                  r_split <= w_split;
                  r_size  <= req_size_i;
                  r_off   <= w_off;
                  r_bm_hi <= w_bm[7:4];
                  r_wdata <= req_wdata_i;
                  r_buf   <= 32'b0;
               end
            end
            S_FIRST:  r_buf <= dmem_rdata_i >> {r_off, 3'b000};
            S_SECOND: r_buf <= r_buf | (dmem_rdata_i << w_sh_hi);
            default: ;
         endcase
      end
   end

   always_comb begin
      w_ext = r_buf;
      case (r_size)
         2'b00:   w_ext = {{24{~r_uns & r_buf[7]}},  r_buf[7:0]};
         2'b01:   w_ext = {{16{~r_uns & r_buf[15]}}, r_buf[15:0]};
         default: ;
      endcase
   end

   assign rsp_valid_o = (r_state == S_DONE);
   assign rsp_err_o   = rsp_valid_o && r_err;
   assign rsp_rdata_o = (rsp_valid_o && !r_we && !r_err) ? w_ext : 32'b0;

endmodule

// File: tb/tb_my_lsu.sv
// Directed bench for my_lsu: word-array dmem model, one DUT with split
// accesses enabled and one with them rejected.
module tb_my_lsu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, v0, v1, we, uns, sel;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic        d1_rdy, d1_rv, d1_err, d1_we;
   logic [3:0]  d1_mask;
   logic [31:0] d1_rdata, d1_addr, d1_wdata, d1_mrd;
   logic        d0_rdy, d0_rv, d0_err, d0_we;
   logic [3:0]  d0_mask;
   logic [31:0] d0_rdata, d0_addr, d0_wdata, d0_mrd;

   bit [31:0] mem [0:63];
   assign d1_mrd = mem[d1_addr[7:2]];
   assign d0_mrd = mem[d0_addr[7:2]];

   always @(posedge clk)
      if (d1_we)
         for (int b = 0; b < 4; b++)
            if (d1_mask[b]) mem[d1_addr[7:2]][8*b +: 8] <= d1_wdata[8*b +: 8];

   my_lsu #(.ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(d1_rdy),
      .req_we_i(we), .req_size_i(size), .req_unsigned_i(uns),
      .req_addr_i(addr), .req_wdata_i(wdata),
      .rsp_valid_o(d1_rv), .rsp_rdata_o(d1_rdata), .rsp_err_o(d1_err),
      .dmem_we_o(d1_we), .dmem_wmask_o(d1_mask), .dmem_addr_o(d1_addr),
      .dmem_wdata_o(d1_wdata), .dmem_rdata_i(d1_mrd));

   my_lsu #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(d0_rdy),
      .req_we_i(we), .req_size_i(size), .req_unsigned_i(uns),
      .req_addr_i(addr), .req_wdata_i(wdata),
      .rsp_valid_o(d0_rv), .rsp_rdata_o(d0_rdata), .rsp_err_o(d0_err),
      .dmem_we_o(d0_we), .dmem_wmask_o(d0_mask), .dmem_addr_o(d0_addr),
      .dmem_wdata_o(d0_wdata), .dmem_rdata_i(d0_mrd));

   logic        o_rdy, o_rv, o_err, o_we;
   logic [3:0]  o_mask;
   logic [31:0] o_rdata, o_addr, o_wdata;
   assign o_rdy   = sel ? d0_rdy   : d1_rdy;
   assign o_rv    = sel ? d0_rv    : d1_rv;
   assign o_err   = sel ? d0_err   : d1_err;
   assign o_we    = sel ? d0_we    : d1_we;
   assign o_mask  = sel ? d0_mask  : d1_mask;
   assign o_rdata = sel ? d0_rdata : d1_rdata;
   assign o_addr  = sel ? d0_addr  : d1_addr;
   assign o_wdata = sel ? d0_wdata : d1_wdata;

   int nvec = 0, nerr = 0;
   int lat, nwe;
   logic        c1we, c1rdy, er;
   logic [3:0]  c1mask, c2mask;
   logic [31:0] c1addr, c1wdata, c2addr, c2wdata, rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request; records the first two access cycles and the response.
   task automatic run(input logic s, input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = s; we = w; size = sz; uns = u; addr = a; wdata = d;
      if (s) v0 = 1'b1; else v1 = 1'b1;
      @(posedge clk);
      lat = 0; nwe = 0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            v0 = 1'b0; v1 = 1'b0;
            c1we = o_we; c1mask = o_mask; c1addr = o_addr; c1wdata = o_wdata; c1rdy = o_rdy;
         end
         if (k == 2) begin
            c2mask = o_mask; c2addr = o_addr; c2wdata = o_wdata;
         end
         if (o_we) nwe++;
         if (o_rv) begin
            lat = k; rd = o_rdata; er = o_err;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; sel = 1'b0; we = 1'b0; uns = 1'b0;
      size = 2'b0; addr = 32'b0; wdata = 32'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",  d1_rdy,   1);
      chk("rst_ready0", d0_rdy,   1);
      chk("rst_rvalid", d1_rv,    0);
      chk("rst_err",    d1_err,   0);
      chk("rst_rdata",  d1_rdata, 0);
      chk("rst_we",     d1_we,    0);
      chk("rst_mask",   d1_mask,  0);
      chk("rst_addr",   d1_addr,  0);
      chk("rst_wdata",  d1_wdata, 0);
      rst = 1'b0;

      run(0, 1, 2'b10, 0, 32'h10000010, 32'hDEADBEEF);
      chk("sw_we", c1we, 1);   chk("sw_mask", c1mask, 4'hF);
      chk("sw_addr", c1addr, 32'h10000010); chk("sw_wdata", c1wdata, 32'hDEADBEEF);
      chk("sw_rdy_drop", c1rdy, 0); chk("sw_lat", lat, 2);
      chk("sw_rdata", rd, 0);  chk("sw_err", er, 0);
      run(0, 0, 2'b10, 0, 32'h10000010, 32'h0);
      chk("lw_we", c1we, 0);   chk("lw_lat", lat, 2); chk("lw_rdata", rd, 32'hDEADBEEF);

      run(0, 1, 2'b00, 0, 32'h10000003, 32'h000000A5);
      chk("sb_mask", c1mask, 4'h8); chk("sb_addr", c1addr, 32'h10000000);
      chk("sb_wdata", c1wdata, 32'hA5000000); chk("sb_lat", lat, 2);
      run(0, 0, 2'b00, 1, 32'h10000003, 32'h0);
      chk("lbu_rdata", rd, 32'h000000A5);
      run(0, 0, 2'b00, 0, 32'h10000003, 32'h0);
      chk("lb_rdata", rd, 32'hFFFFFFA5);

      run(0, 1, 2'b10, 0, 32'h10000000, 32'h00800100);
      run(0, 0, 2'b01, 0, 32'h10000001, 32'h0);
      chk("lh_lat", lat, 2); chk("lh_rdata", rd, 32'hFFFF8001);
      run(0, 0, 2'b01, 1, 32'h10000001, 32'h0);
      chk("lhu_rdata", rd, 32'h00008001);

      run(0, 1, 2'b10, 0, 32'h10000006, 32'h11223344);
      chk("ssw_a1", c1addr, 32'h10000004); chk("ssw_m1", c1mask, 4'hC);
      chk("ssw_d1", c1wdata, 32'h33440000);
      chk("ssw_a2", c2addr, 32'h10000008); chk("ssw_m2", c2mask, 4'h3);
      chk("ssw_d2", c2wdata, 32'h00001122); chk("ssw_lat", lat, 3);
      run(0, 0, 2'b10, 0, 32'h10000006, 32'h0);
      chk("slw_lat", lat, 3); chk("slw_rdata", rd, 32'h11223344);

      run(0, 0, 2'b11, 0, 32'h10000010, 32'h0);
      chk("ill_ld_lat", lat, 1); chk("ill_ld_err", er, 1);
      chk("ill_ld_rdata", rd, 0); chk("ill_ld_nwe", nwe, 0);
      run(0, 1, 2'b11, 0, 32'h10000010, 32'hFFFFFFFF);
      chk("ill_st_lat", lat, 1); chk("ill_st_err", er, 1); chk("ill_st_nwe", nwe, 0);

      run(1, 0, 2'b10, 0, 32'h10000002, 32'h0);
      chk("nomis_lat", lat, 1); chk("nomis_err", er, 1);
      chk("nomis_rdata", rd, 0); chk("nomis_nwe", nwe, 0);
      run(1, 1, 2'b01, 0, 32'h10000003, 32'h0000BEEF);
      chk("nomis_sh_err", er, 1); chk("nomis_sh_nwe", nwe, 0);
      run(1, 0, 2'b10, 0, 32'h10000010, 32'h0);
      chk("nomis_lw_lat", lat, 2); chk("nomis_lw_err", er, 0);
      chk("nomis_lw_rdata", rd, 32'hDEADBEEF);

      run(0, 1, 2'b10, 0, 32'hFFFFFFFD, 32'hA1B2C3D4);
      chk("wrap_a1", c1addr, 32'hFFFFFFFC); chk("wrap_m1", c1mask, 4'hE);
      chk("wrap_d1", c1wdata, 32'hB2C3D400);
      chk("wrap_a2", c2addr, 32'h00000000); chk("wrap_m2", c2mask, 4'h1);
      chk("wrap_d2", c2wdata, 32'h000000A1);
      run(0, 0, 2'b10, 0, 32'hFFFFFFFD, 32'h0);
      chk("wrap_lw", rd, 32'hA1B2C3D4);

      // reset asserted during SECOND of a split store
      @(negedge clk);
      sel = 0; we = 1; size = 2'b10; uns = 0; addr = 32'h10000022; wdata = 32'h55667788; v1 = 1;
      @(posedge clk); @(negedge clk); v1 = 0;
      @(posedge clk); @(negedge clk);
      chk("rs2_we_second", d1_we, 1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rs2_ready", d1_rdy, 1); chk("rs2_we", d1_we, 0); chk("rs2_rv", d1_rv, 0);
      @(posedge clk); @(negedge clk);
      chk("rs2_rv_after", d1_rv, 0);
      run(0, 0, 2'b10, 0, 32'h10000022, 32'h0);
      chk("rs2_lw", rd, 32'h55667788);

      // reset asserted during FIRST: only the first half commits
      @(negedge clk);
      sel = 0; we = 1; size = 2'b10; uns = 0; addr = 32'h10000032; wdata = 32'h99AABBCC; v1 = 1;
      @(posedge clk); @(negedge clk); v1 = 0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rs1_ready", d1_rdy, 1); chk("rs1_we", d1_we, 0); chk("rs1_rv", d1_rv, 0);
      run(0, 0, 2'b10, 0, 32'h10000032, 32'h0);
      chk("rs1_lw", rd, 32'h0000BBCC);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
